mb11_dot_seq: RTL and testbench
===============================

# mb11_dot_seq

Sequencer for the shared 11×11 radix-4 Booth multiplier in the Kulisch accumulation path. It accepts a length-N stream of signed operand pairs over a valid/ready handshake and drives the multiplier operands from registers. It resolves each redundant sum/carry product into a two's-complement value and accumulates N products into a wide signed result, reporting completion with a one-cycle `done` pulse.

## Interface
- `WIDTH`, 11, operand width; the multiplier produces 2*WIDTH-bit sum/carry vectors.
- `LEN_W`, 8, width of the vector-length field; maximum N = 2^LEN_W−1.
- `ACC_W`, 32, accumulator/result width; must be ≥ 2*WIDTH.

- `CLK` in 1: the single clock; all state updates on its rising edge.
- `RST` in 1: reset, asynchronous and active-low.
- `start` in 1: begin a dot product; sampled only in IDLE.
- `len` in LEN_W: element count N, sampled together with `start`.
- `busy` out 1: high whenever the state is not IDLE.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: the block can accept an operand pair.
- `in_x` in WIDTH: signed multiplicand.
- `in_y` in WIDTH: signed multiplier.
- `mul_x` out WIDTH: registered operand to the multiplier's `mx`.
- `mul_y` out WIDTH: registered operand to the multiplier's `my`.
- `mul_sum` in 2*WIDTH: multiplier sum vector (combinational return).
- `mul_carry` in 2*WIDTH: multiplier carry vector.
- `result` out ACC_W: signed accumulated dot product.
- `ovf` out 1: sticky overflow flag for the current result.
- `done` out 1: one-cycle completion pulse.

## Operation
- States:
  - IDLE: waits for `start`.
  - LOAD: accepts operand pairs.
  - DRAIN: empties the pipeline.
  - DONE: signals completion.
- IDLE: `start`=1 latches `len` into a remaining-count `cnt` and clears the accumulator and `ovf`.
  - If `len`≠0, go to LOAD.
  - If `len`=0, go to DONE; `result` is then 0.
- `in_ready` = (state==LOAD).
- An accept is `in_valid & in_ready` at an edge. On each accept:
  - `mul_x`/`mul_y` ← `in_x`/`in_y`.
  - `v1` ← 1 and `cnt` ← `cnt`−1.
  - If `cnt` was 1, go to DRAIN.
- Without an accept: `v1` ← 0 and `mul_x`/`mul_y` hold their values.
- Stage 2, every edge:
  - `p` ← (`mul_sum` + `mul_carry`) mod 2^(2*WIDTH), treated as signed.
  - `v2` ← `v1`.
- Stage 3, when `v2`=1: accumulator ← accumulator + sign-extend(`p`, ACC_W).
- DRAIN goes to DONE at the first edge where `v1`=0 and `v2`=0 (registered values).
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `result` is the accumulator register. It and `ovf` hold until the next accepted `start`.
- `start` outside IDLE is ignored. `in_valid` outside LOAD is ignored.
- Overflow: signed overflow of an accumulate step is detected as "operand signs equal and sum sign different". Handling depends on the configuration below.

## Timing
- Reset values: state IDLE, `busy`=0, `in_ready`=0, `done`=0, `ovf`=0, `result`=0, `mul_x`=`mul_y`=0, `v1`=`v2`=0, `cnt`=0, `p`=0.
- Reset asserted mid-operation aborts immediately. Deasserted, the block is in IDLE with all of the above values.
- The `start` edge enters LOAD; `in_ready` is high from the next cycle.
- Throughput is one pair per cycle while `in_valid` is held high. Bubbles are allowed at any point.
- For a pair accepted at edge t:
  - operands are on `mul_x`/`mul_y` after t;
  - `p` is registered at t+1;
  - the accumulator is updated at t+2.
- For the last pair accepted at edge t:
  - LOAD→DRAIN at t;
  - DRAIN→DONE at t+3;
  - `done` is high in the cycle after t+3, with the final `result` already valid;
  - the block returns to IDLE at t+4.
- `len`=0: IDLE→DONE at the `start` edge, `done` high the next cycle.
- A new `start` is accepted in the IDLE cycle immediately after DONE.

## Configuration
- `MB11_SEQ_SAT_EN` defined:
  - On overflow, the accumulator saturates to +2^(ACC_W−1)−1 or −2^(ACC_W−1) according to operand sign, and `ovf` is set.
  - Saturation is sticky for the remainder of the vector.
- Undefined:
  - The accumulator wraps modulo 2^ACC_W.
  - `ovf` is constant 0.

## Test plan
- `len`=3, pairs (3,5), (−7,2), (100,−4): `done` 3 cycles after the last accept, `result`=−399, `ovf`=0.
- `len`=0: `done` the cycle after `start`, `result`=0, `in_ready` never high.
- `len`=1, (−1024,−1024): `result`=1048576 (sum/carry resolution of the extreme Booth case).
- `len`=4 with `in_valid` gaps of 0–3 cycles, pairs (1,1), (2,2), (3,3), (4,4): `result`=30; `start` pulsed during LOAD is ignored.
- `ACC_W`=24, `len`=8, all (−1024,−1024):
  - with `MB11_SEQ_SAT_EN`: `result`=8388607, `ovf`=1;
  - without: `result`=−8388608, `ovf`=0.
- Reset asserted mid-LOAD after 2 of 5 accepts: all outputs return to their reset values immediately. A following `len`=1, (2,3) run gives `result`=6.

Source files
------------

// File: rtl/mb11_dot_seq.sv
// rtl/mb11_dot_seq.sv - dot-product sequencer for the shared 11x11 Booth multiplier
// Optional feature macro: MB11_SEQ_SAT_EN (saturating accumulate with sticky ovf).
module mb11_dot_seq #(
  parameter int WIDTH = 11,
  parameter int LEN_W = 8,
  parameter int ACC_W = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [WIDTH-1:0]     in_y,
  output logic [WIDTH-1:0]     mul_x,
  output logic [WIDTH-1:0]     mul_y,
  input  logic [2*WIDTH-1:0]   mul_sum,
  input  logic [2*WIDTH-1:0]   mul_carry,
  output logic [ACC_W-1:0]     result,
  output logic                 ovf,
  output logic                 done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t                     state, state_nx;
  logic [LEN_W-1:0]           cnt;
  logic                       v1, v2;
  logic signed [2*WIDTH-1:0]  p;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    p_ext;
  logic signed [ACC_W-1:0]    acc_sum;
  logic                       accept;

  assign accept  = in_valid & in_ready;
  assign p_ext   = ACC_W'(p);
  assign acc_sum = acc + p_ext;
  assign result  = acc;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = (len != '0) ? S_LOAD : S_DONE;
      S_LOAD:  if (accept && cnt == LEN_W'(1)) state_nx = S_DRAIN;
      // v1/v2 are the registered pipeline valids; both clear means the last product is in.
      S_DRAIN: if (!v1 && !v2) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != S_IDLE);
    in_ready = (state == S_LOAD);
    done     = (state == S_DONE);
  end

`ifdef MB11_SEQ_SAT_EN
  logic ovf_r;
  logic step_ovf;
  assign step_ovf = (acc[ACC_W-1] == p_ext[ACC_W-1]) && (acc_sum[ACC_W-1] != acc[ACC_W-1]);
  assign ovf      = ovf_r;
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt   <= '0;
      mul_x <= '0;
      mul_y <= '0;
      v1    <= 1'b0;
      v2    <= 1'b0;
      p     <= '0;
      acc   <= '0;
`ifdef MB11_SEQ_SAT_EN
      ovf_r <= 1'b0;
`endif
    end else begin
      if (state == S_IDLE && start) begin
        cnt <= len;
        acc <= '0;
`ifdef MB11_SEQ_SAT_EN
        ovf_r <= 1'b0;
`endif
      end else if (v2) begin
`ifdef MB11_SEQ_SAT_EN
        // Once saturated the accumulator is frozen for the rest of the vector.
        if (!ovf_r) begin
          if (step_ovf) begin
            acc   <= p_ext[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            ovf_r <= 1'b1;
          end else begin
            acc <= acc_sum;
          end
        end
`else
        acc <= acc_sum;
`endif
      end

      if (accept) begin
        mul_x <= in_x;
        mul_y <= in_y;
        v1    <= 1'b1;
        cnt   <= cnt - 1'b1;
      end else begin
        v1 <= 1'b0;
      end

      p  <= mul_sum + mul_carry;
      v2 <= v1;
    end
  end

endmodule

// File: tb/tb_mb11_dot_seq.sv
// tb/tb_mb11_dot_seq.sv - randomized self-checking bench for mb11_dot_seq (ACC_W 32 and 24)
module tb_mb11_dot_seq;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [10:0] in_x, in_y;
  logic [21:0] salt;

  logic        busy32, in_ready32, ovf32, done32;
  logic [10:0] mul_x32, mul_y32;
  logic [21:0] sum32, carry32;
  logic [31:0] result32;
  logic signed [21:0] prod32;

  logic        busy24, in_ready24, ovf24, done24;
  logic [10:0] mul_x24, mul_y24;
  logic [21:0] sum24, carry24;
  logic [23:0] result24;
  logic signed [21:0] prod24;

  int total = 0;
  int bad   = 0;
  int xs[256];
  int ys[256];

  always #5 CLK = ~CLK;

  // Multiplier stand-in: exact product split into a salted redundant sum/carry pair.
  assign prod32  = $signed(mul_x32) * $signed(mul_y32);
  assign carry32 = {mul_y32, mul_x32} ^ salt;
  assign sum32   = prod32 - carry32;
  assign prod24  = $signed(mul_x24) * $signed(mul_y24);
  assign carry24 = {mul_x24, mul_y24} ^ ~salt;
  assign sum24   = prod24 - carry24;

  mb11_dot_seq #(.WIDTH(11), .LEN_W(8), .ACC_W(32)) d32 (
    .CLK(CLK), .RST(RST), .start(start), .len(len), .busy(busy32),
    .in_valid(in_valid), .in_ready(in_ready32), .in_x(in_x), .in_y(in_y),
    .mul_x(mul_x32), .mul_y(mul_y32), .mul_sum(sum32), .mul_carry(carry32),
    .result(result32), .ovf(ovf32), .done(done32));

  mb11_dot_seq #(.WIDTH(11), .LEN_W(8), .ACC_W(24)) d24 (
    .CLK(CLK), .RST(RST), .start(start), .len(len), .busy(busy24),
    .in_valid(in_valid), .in_ready(in_ready24), .in_x(in_x), .in_y(in_y),
    .mul_x(mul_x24), .mul_y(mul_y24), .mul_sum(sum24), .mul_carry(carry24),
    .result(result24), .ovf(ovf24), .done(done24));

  // Reference: plain integer dot product, then wrap or saturate to accw bits.
  task automatic model(input int n, input int accw, output longint res, output bit o);
    longint acc = 0;
    longint mx  = (longint'(1) <<< (accw - 1)) - 1;
    longint mn  = -(longint'(1) <<< (accw - 1));
    longint md  = longint'(1) <<< accw;
    bit sat = 0;
    for (int i = 0; i < n; i++) begin
`ifdef MB11_SEQ_SAT_EN
      if (!sat) begin
        acc = acc + longint'(xs[i]) * longint'(ys[i]);
        if (acc > mx) begin acc = mx; sat = 1; end
        else if (acc < mn) begin acc = mn; sat = 1; end
      end
`else
      acc = acc + longint'(xs[i]) * longint'(ys[i]);
`endif
    end
`ifndef MB11_SEQ_SAT_EN
    acc = acc % md;
    if (acc < 0) acc = acc + md;
    if (acc > mx) acc = acc - md;
`endif
    res = acc;
    o   = sat;
  endtask

  task automatic run_dot(input int n, input int max_gap, input bit poke, input bit junk, input string name);
    longint e32, e24;
    bit o32, o24;
    int k, g;
    model(n, 32, e32, o32);
    model(n, 24, e24, o24);
    salt  = 22'($urandom);
    start = 1'b1;
    len   = 8'(n);
    @(negedge CLK);
    start = 1'b0;
    total++;
    if (busy32 !== 1'b1) begin bad++; $display("FAIL %s busy_after_start got=%b exp=1", name, busy32); end
    for (int i = 0; i < n; i++) begin
      g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int j = 0; j < g; j++) begin
        in_valid = 1'b0;
        in_x = 11'($urandom);
        if (poke) begin start = 1'b1; len = 8'($urandom); end
        @(negedge CLK);
        start = 1'b0;
      end
      in_valid = 1'b1;
      in_x = 11'(xs[i]);
      in_y = 11'(ys[i]);
      total++;
      if (in_ready32 !== 1'b1) begin bad++; $display("FAIL %s in_ready[%0d] got=%b exp=1", name, i, in_ready32); end
      @(negedge CLK);
    end
    in_valid = junk;
    in_x = 11'($urandom);
    in_y = 11'($urandom);
    k = 0;
    while (done32 !== 1'b1 && k < 8) begin
      @(negedge CLK);
      k++;
    end
    total++;
    if (k != ((n == 0) ? 0 : 3)) begin bad++; $display("FAIL %s done_latency got=%0d exp=%0d", name, k, (n == 0) ? 0 : 3); end
    total++;
    if (done24 !== done32) begin bad++; $display("FAIL %s done24 got=%b exp=%b", name, done24, done32); end
    total++;
    if (in_ready32 !== 1'b0) begin bad++; $display("FAIL %s in_ready_at_done got=%b exp=0", name, in_ready32); end
    total++;
    if (longint'($signed(result32)) != e32) begin bad++; $display("FAIL %s result32 got=%0d exp=%0d", name, $signed(result32), e32); end
    total++;
    if (ovf32 !== o32) begin bad++; $display("FAIL %s ovf32 got=%b exp=%b", name, ovf32, o32); end
    total++;
    if (longint'($signed(result24)) != e24) begin bad++; $display("FAIL %s result24 got=%0d exp=%0d", name, $signed(result24), e24); end
    total++;
    if (ovf24 !== o24) begin bad++; $display("FAIL %s ovf24 got=%b exp=%b", name, ovf24, o24); end
    @(negedge CLK);
    in_valid = 1'b0;
    total++;
    if (done32 !== 1'b0 || busy32 !== 1'b0) begin
      bad++; $display("FAIL %s idle_after_done got done=%b busy=%b exp=0/0", name, done32, busy32);
    end
    total++;
    if (longint'($signed(result32)) != e32) begin bad++; $display("FAIL %s result_hold got=%0d exp=%0d", name, $signed(result32), e32); end
  endtask

  task automatic check_reset_vals(input string name);
    total++;
    if (busy32 !== 0 || in_ready32 !== 0 || done32 !== 0 || ovf32 !== 0 || result32 !== 0 ||
        mul_x32 !== 0 || mul_y32 !== 0)
      begin bad++; $display("FAIL %s d32 got busy=%b rdy=%b done=%b ovf=%b res=%h mx=%h my=%h exp=all0",
                            name, busy32, in_ready32, done32, ovf32, result32, mul_x32, mul_y32); end
    total++;
    if (busy24 !== 0 || in_ready24 !== 0 || done24 !== 0 || ovf24 !== 0 || result24 !== 0 ||
        mul_x24 !== 0 || mul_y24 !== 0)
      begin bad++; $display("FAIL %s d24 got busy=%b rdy=%b done=%b ovf=%b res=%h exp=all0",
                            name, busy24, in_ready24, done24, ovf24, result24); end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    check_reset_vals("reset");
    RST = 1'b1;
    @(negedge CLK);
    check_reset_vals("after_reset");
  endtask

  task automatic test_basic();
    xs[0] = 3;   ys[0] = 5;
    xs[1] = -7;  ys[1] = 2;
    xs[2] = 100; ys[2] = -4;
    run_dot(3, 0, 0, 0, "basic");
  endtask

  task automatic test_len0();
    run_dot(0, 0, 0, 1, "len0");
  endtask

  task automatic test_extreme();
    xs[0] = -1024; ys[0] = -1024;
    run_dot(1, 0, 0, 0, "extreme");
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 4; i++) begin xs[i] = i + 1; ys[i] = i + 1; end
    run_dot(4, 3, 1, 1, "gaps");
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 8; i++) begin xs[i] = -1024; ys[i] = -1024; end
    run_dot(8, 0, 0, 0, "acc24_overflow");
  endtask

  task automatic test_random();
    int n;
    for (int v = 0; v < 12; v++) begin
      n = int'($urandom_range(1, 40));
      for (int i = 0; i < n; i++) begin
        xs[i] = int'($urandom_range(0, 2047)) - 1024;
        ys[i] = int'($urandom_range(0, 2047)) - 1024;
      end
      run_dot(n, (v % 3 == 0) ? 0 : 2, v[0], v[1], $sformatf("rand%0d", v));
    end
  endtask

  task automatic test_back_to_back();
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < v + 1; i++) begin
        xs[i] = int'($urandom_range(0, 2047)) - 1024;
        ys[i] = 1023;
      end
      run_dot(v + 1, 0, 0, 0, $sformatf("b2b%0d", v));
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    len   = 8'd5;
    @(negedge CLK);
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_x = 11'(i + 9);
      in_y = 11'(i + 7);
      @(negedge CLK);
    end
    RST = 1'b0;
    #1;
    check_reset_vals("reset_mid");
    in_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    xs[0] = 2; ys[0] = 3;
    run_dot(1, 0, 0, 0, "after_abort");
  endtask

  initial begin
    RST = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_x = '0; in_y = '0; salt = '0;
    test_reset();
    test_basic();
    test_len0();
    test_extreme();
    test_gaps();
    test_saturate();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
